tiger_sbox_arb: RTL and testbench

// - Shares one set of four Tiger S-box ROMs (T1..T4; 8-bit address, 64-bit data, synchronous read) between two round engines.
// - Per granted request, sequences the eight byte lookups of one Tiger round on a 64-bit word c:
//   - even = T1[c0]^T2[c2]^T3[c4]^T4[c6]
//   - odd  = T4[c1]^T3[c3]^T2[c5]^T1[c7]
//   - cK = c[8K+7:8K]
// - Sits between tiger_round cores and the tiger_sbox_a..d instances in the hash top.

---
 rtl/tiger_sbox_arb_pkg.sv | 33 +++
 rtl/tiger_lat_pipe.sv | 29 ++
 rtl/tiger_sbox_arb.sv | 141 ++++++++++++++
 tb/tb_tiger_sbox_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tiger_sbox_arb_pkg.sv
// Shared types for the Tiger S-box arbiter: FSM states, lookup tags, byte lanes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tiger_sbox_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE_EVEN = 3'd1,
    S_ISSUE_ODD  = 3'd2,
    S_WAIT       = 3'd3,
    S_RESP       = 3'd4
  } state_t;

  // Tags travel alongside the ROM reads so the result lands in the right half.
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_EVEN = 2'd1;
  localparam logic [1:0] TAG_ODD  = 2'd2;

  // Byte lanes of the c word, cK = c[8K+7:8K].
  localparam int LANE_C0 = 0;
  localparam int LANE_C1 = 1;
  localparam int LANE_C2 = 2;
  localparam int LANE_C3 = 3;
  localparam int LANE_C4 = 4;
  localparam int LANE_C5 = 5;
  localparam int LANE_C6 = 6;
  localparam int LANE_C7 = 7;

  function automatic logic [7:0] lane(input logic [63:0] c, input int k);
    return c[8*k +: 8];
  endfunction

endpackage

// File: rtl/tiger_lat_pipe.sv
// Tag shift register that tracks outstanding ROM reads.
// Latency: DEPTH cycles from i_tag to o_tag.
// Backpressure: none; shifts every cycle, sync active-low clear to TAG_NONE.
// Ports: i_clk, i_rst_n (sync, active-low), i_tag (2b tag in), o_tag (2b tag out).
module tiger_lat_pipe
  import tiger_sbox_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_tag,
  output logic [1:0] o_tag
);

  logic [1:0] stage_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign o_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/tiger_sbox_arb.sv
// Shares four Tiger S-box ROMs between two round engines; per grant, does one round's 8 lookups.
// Latency: accept -> o_rsp_valid = ROM_LAT+3 cycles; one request per ROM_LAT+4 cycles at best.
// Backpressure: response held stable until i_rsp_ready[grant]; no new accept until it is taken.
// Ports: i_clk, i_rst_n (sync active-low); i_req_valid/o_req_ready[1:0], i_req_c0/c1 (64b c words);
//        o_rsp_valid/i_rsp_ready[1:0], o_rsp_even/o_rsp_odd (64b); o_tK_addr (8b) / i_tK_data (64b)
//        for ROMs T1..T4; o_busy.
module tiger_sbox_arb
  import tiger_sbox_arb_pkg::*;
#(
  parameter int DLY     = 1,
  parameter int ROM_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req_valid,
  input  logic [63:0] i_req_c0,
  input  logic [63:0] i_req_c1,
  output logic [1:0]  o_req_ready,
  output logic [1:0]  o_rsp_valid,
  input  logic [1:0]  i_rsp_ready,
  output logic [63:0] o_rsp_even,
  output logic [63:0] o_rsp_odd,
  output logic [7:0]  o_t1_addr,
  output logic [7:0]  o_t2_addr,
  output logic [7:0]  o_t3_addr,
  output logic [7:0]  o_t4_addr,
  input  logic [63:0] i_t1_data,
  input  logic [63:0] i_t2_data,
  input  logic [63:0] i_t3_data,
  input  logic [63:0] i_t4_data,
  output logic        o_busy
);

  if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_rom_lat
    $error("tiger_sbox_arb: ROM_LAT=%0d outside legal range 1..3", ROM_LAT);
  end

  // DLY is accepted so existing parents can keep setting it; this RTL inserts no delays.
  if (DLY < 0) begin : g_bad_dly
    $error("tiger_sbox_arb: DLY=%0d must not be negative", DLY);
  end

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        grant_q;
  logic        ready_en_q;   // keeps o_req_ready low in the first cycle out of reset
  logic [63:0] c_q;
  logic [63:0] even_q, odd_q;
  logic        gnt_sel;
  logic        accept;
  logic        rsp_done;
  logic [1:0]  tag_in, tag_out;
  logic [63:0] rom_xor;

  // Round-robin only matters when both ask; a lone requester always wins.
  always_comb begin
    gnt_sel = 1'b0;
    if (i_req_valid == 2'b11) gnt_sel = ~last_grant_q;
    else if (i_req_valid[1])  gnt_sel = 1'b1;
  end

  assign o_req_ready = (state_q == S_IDLE && ready_en_q && (|i_req_valid))
                       ? (2'b01 << gnt_sel) : 2'b00;
  // Ready is only raised towards a valid requester, so ready alone implies the handshake.
  assign accept   = |o_req_ready;
  assign rsp_done = (state_q == S_RESP) && i_rsp_ready[grant_q];
  assign rom_xor  = i_t1_data ^ i_t2_data ^ i_t3_data ^ i_t4_data;

  always_comb begin
    state_d   = state_q;
    tag_in    = TAG_NONE;
    o_t1_addr = 8'h00;
    o_t2_addr = 8'h00;
    o_t3_addr = 8'h00;
    o_t4_addr = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ISSUE_EVEN;
      end
      S_ISSUE_EVEN: begin
        o_t1_addr = lane(c_q, LANE_C0);
        o_t2_addr = lane(c_q, LANE_C2);
        o_t3_addr = lane(c_q, LANE_C4);
        o_t4_addr = lane(c_q, LANE_C6);
        tag_in    = TAG_EVEN;
        state_d   = S_ISSUE_ODD;
      end
      S_ISSUE_ODD: begin
        // Odd half walks the ROMs in reverse: T1 takes c7, T4 takes c1.
        o_t1_addr = lane(c_q, LANE_C7);
        o_t2_addr = lane(c_q, LANE_C5);
        o_t3_addr = lane(c_q, LANE_C3);
        o_t4_addr = lane(c_q, LANE_C1);
        tag_in    = TAG_ODD;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (tag_out == TAG_ODD) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  tiger_lat_pipe #(.DEPTH(ROM_LAT)) u_lat_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tag   (tag_in),
    .o_tag   (tag_out)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      ready_en_q   <= 1'b0;
      c_q          <= '0;
      even_q       <= '0;
      odd_q        <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (accept) begin
        c_q          <= gnt_sel ? i_req_c1 : i_req_c0;
        grant_q      <= gnt_sel;
        last_grant_q <= gnt_sel;
      end
      if (tag_out == TAG_EVEN) even_q <= rom_xor;
      if (tag_out == TAG_ODD)  odd_q  <= rom_xor;
    end
  end

  assign o_rsp_valid = (state_q == S_RESP) ? (2'b01 << grant_q) : 2'b00;
  assign o_rsp_even  = even_q;
  assign o_rsp_odd   = odd_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tiger_sbox_arb.sv
// Directed bench for tiger_sbox_arb at ROM_LAT 1, 2 and 3 with stub ROMs behind each instance.
// Latency: n/a.
// Backpressure: driven explicitly by the directed steps.
module tb_tiger_sbox_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_mode;   // 1: instance 0 sees T3 = real sbox_c entries, others zero

  logic [1:0]  req_valid [3];
  logic [63:0] c0 [3];
  logic [63:0] c1 [3];
  logic [1:0]  ready [3];
  logic [1:0]  rsp_valid [3];
  logic [1:0]  rsp_ready [3];
  logic [63:0] even [3];
  logic [63:0] odd [3];
  logic        busy [3];
  logic [7:0]  addr [3][4];
  logic [63:0] data [3][4];
  logic [7:0]  apipe [3][4][3];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar d = 0; d < 3; d++) begin : g_dut
    tiger_sbox_arb #(.DLY(1), .ROM_LAT(d + 1)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid[d]),
      .i_req_c0    (c0[d]),
      .i_req_c1    (c1[d]),
      .o_req_ready (ready[d]),
      .o_rsp_valid (rsp_valid[d]),
      .i_rsp_ready (rsp_ready[d]),
      .o_rsp_even  (even[d]),
      .o_rsp_odd   (odd[d]),
      .o_t1_addr   (addr[d][0]),
      .o_t2_addr   (addr[d][1]),
      .o_t3_addr   (addr[d][2]),
      .o_t4_addr   (addr[d][3]),
      .i_t1_data   (data[d][0]),
      .i_t2_data   (data[d][1]),
      .i_t3_data   (data[d][2]),
      .i_t4_data   (data[d][3]),
      .o_busy      (busy[d])
    );
  end

  // Known entries of Tiger sbox T3 (tiger_sbox_c) used by the real-ROM step.
  function automatic logic [63:0] t3_real(input logic [7:0] a);
    case (a)
      8'h00:   return 64'hf49fcc2ff1daf39b;
      8'hff:   return 64'h6d0e60f5c3578a9e;
      default: return 64'h0;
    endcase
  endfunction

  // Stub TK returns the address in byte lane K-1.
  function automatic logic [63:0] rom(input int k, input logic [7:0] a, input logic real_mode);
    if (real_mode) return (k == 2) ? t3_real(a) : 64'h0;
    return {56'h0, a} << (8 * k);
  endfunction

  // Expected results with stub ROMs, straight from the lookup equations.
  function automatic logic [63:0] stub_even(input logic [63:0] c);
    return {32'h0, c[55:48], c[39:32], c[23:16], c[7:0]};
  endfunction
  function automatic logic [63:0] stub_odd(input logic [63:0] c);
    return {32'h0, c[15:8], c[31:24], c[47:40], c[63:56]};
  endfunction

  // ROM model: instance d has read latency d+1.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) begin
        apipe[d][k][0] <= addr[d][k];
        apipe[d][k][1] <= apipe[d][k][0];
        apipe[d][k][2] <= apipe[d][k][1];
      end
  end

  always_comb begin
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++)
        data[d][k] = rom(k, apipe[d][k][d], rom_mode && (d == 0));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request on instance d from requester r, wait for accept (bounded), check the
  // response at exactly `lat` cycles after accept, hold it for `hold` cycles, then release.
  task automatic serve(input int d, input int r, input logic [63:0] c,
                       input logic [63:0] ee, input logic [63:0] eo,
                       input int lat, input bit keep, input int hold, input string lbl);
    int k;
    logic [1:0] onehot;
    onehot = 2'b01 << r;
    if (r == 0) c0[d] = c; else c1[d] = c;
    req_valid[d][r] = 1'b1;
    k = 0;
    #1;
    while (ready[d] !== onehot && k < 30) begin
      chk({lbl, " ready_not_both"}, 64'(ready[d] == 2'b11), 64'h0);
      @(negedge clk); #1;
      k++;
    end
    chk({lbl, " accept_ready"}, 64'(ready[d]), 64'(onehot));
    @(negedge clk);
    if (!keep) req_valid[d][r] = 1'b0;
    for (int i = 1; i < lat; i++) begin
      #1 chk({lbl, " early_rsp_valid"}, 64'(rsp_valid[d]), 64'h0);
      @(negedge clk);
    end
    #1;
    chk({lbl, " rsp_valid"}, 64'(rsp_valid[d]), 64'(onehot));
    chk({lbl, " even"}, even[d], ee);
    chk({lbl, " odd"}, odd[d], eo);
    for (int h = 0; h < hold; h++) begin
      rsp_ready[d] = ~onehot;   // the other requester's accept must be ignored
      @(negedge clk); #1;
      chk({lbl, " hold_valid"}, 64'(rsp_valid[d]), 64'(onehot));
      chk({lbl, " hold_even"}, even[d], ee);
      chk({lbl, " hold_odd"}, odd[d], eo);
      chk({lbl, " hold_req_ready"}, 64'(ready[d]), 64'h0);
    end
    rsp_ready[d] = onehot;
    @(negedge clk);
    rsp_ready[d] = 2'b00;
    #1;
    chk({lbl, " done_rsp_valid"}, 64'(rsp_valid[d]), 64'h0);
    chk({lbl, " done_idle"}, 64'(busy[d]), 64'h0);
  endtask

  localparam logic [63:0] C_T1 = 64'h0706050403020100;
  localparam logic [63:0] C_A  = 64'h1122334455667788;
  localparam logic [63:0] C_B  = 64'h99aabbccddeeff01;
  localparam logic [63:0] C_X  = 64'hdeadbeefcafef00d;
  localparam logic [63:0] C_Y  = 64'h0f1e2d3c4b5a6978;

  initial begin
    rst_n    = 1'b0;
    rom_mode = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 2'b00;
      rsp_ready[d] = 2'b00;
      c0[d] = '0;
      c1[d] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", 64'(busy[0]), 64'h0);
    chk("reset rsp_valid", 64'(rsp_valid[0]), 64'h0);
    chk("reset req_ready", 64'(ready[0]), 64'h0);
    chk("reset t1_addr", 64'(addr[0][0]), 64'h0);
    chk("reset t4_addr", 64'(addr[0][3]), 64'h0);
    chk("reset even", even[0], 64'h0);
    chk("reset odd", odd[0], 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    c0[0] = C_T1;
    req_valid[0] = 2'b01;
    #1 chk("first cycle req_ready", 64'(ready[0]), 64'h0);
    @(negedge clk);

    // 1. Single request, ROM_LAT=1, hand-computed results
    serve(0, 0, C_T1, 64'h0000000006040200, 64'h0000000001030507, 4, 1'b0, 0, "t1");

    // 2. Both requesters valid from reset: grant order 0,1,0,1
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0[0] = C_A;
    c1[0] = C_B;
    req_valid[0] = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) serve(0, 0, C_A, stub_even(C_A), stub_odd(C_A), 4, 1'b1, 0, "t2 r0");
      else            serve(0, 1, C_B, stub_even(C_B), stub_odd(C_B), 4, 1'b1, 0, "t2 r1");
    end
    req_valid[0] = 2'b00;

    // 3. Backpressure for 10 cycles with requester 1 waiting behind it
    c1[0] = C_Y;
    req_valid[0][1] = 1'b1;
    serve(0, 0, C_X, stub_even(C_X), stub_odd(C_X), 4, 1'b0, 10, "t3 r0");
    serve(0, 1, C_Y, stub_even(C_Y), stub_odd(C_Y), 4, 1'b0, 0, "t3 r1");

    // 4. Reset while in ISSUE_ODD: request is dropped silently
    @(negedge clk);
    c0[0] = C_X;
    req_valid[0] = 2'b01;
    #1 chk("t4 accept_ready", 64'(ready[0]), 64'h1);
    @(negedge clk);
    req_valid[0] = 2'b00;
    #1 chk("t4 issue_even t1_addr", 64'(addr[0][0]), 64'(C_X[7:0]));
    @(negedge clk);
    #1 chk("t4 issue_odd t1_addr", 64'(addr[0][0]), 64'(C_X[63:56]));
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("t4 reset busy", 64'(busy[0]), 64'h0);
    chk("t4 reset t1_addr", 64'(addr[0][0]), 64'h0);
    chk("t4 reset t2_addr", 64'(addr[0][1]), 64'h0);
    chk("t4 reset odd", odd[0], 64'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 chk("t4 no_rsp_after_reset", 64'(rsp_valid[0]), 64'h0);
    end
    serve(0, 1, C_Y, stub_even(C_Y), stub_odd(C_Y), 4, 1'b0, 0, "t4 r1");

    // 5. Real sbox_c entries on T3
    rom_mode = 1'b1;
    serve(0, 0, 64'h00000000ff000000, 64'hf49fcc2ff1daf39b, 64'h6d0e60f5c3578a9e,
          4, 1'b0, 0, "t5");
    rom_mode = 1'b0;

    // 6. Latency sweep: ROM_LAT=2 and 3
    serve(1, 0, C_T1, 64'h0000000006040200, 64'h0000000001030507, 5, 1'b0, 0, "t6 lat2");
    serve(2, 0, C_T1, 64'h0000000006040200, 64'h0000000001030507, 6, 1'b0, 0, "t6 lat3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
